// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps one request outstanding to imem, and feeds IF/ID.
// Define FETCH_PERF_CNT_EN to add the saturating bubble_cnt_o counter.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        stall_i,
   input  logic        redirect_valid_i,
   input  logic [31:0] redirect_pc_i,
   output logic        imem_req_valid_o,
   input  logic        imem_req_ready_i,
   output logic [31:0] imem_addr_o,
   input  logic        imem_rsp_valid_i,
   input  logic [31:0] imem_rsp_data_i,
   output logic [31:0] instd_o,
   output logic [31:0] pcd_o,
   output logic        flush_o
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] bubble_cnt_o
`endif
);

   typedef enum logic [1:0] {ST_REQ, ST_WAIT, ST_DROP} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] req_pc_q, req_pc_d;
   logic        slot_v_q, slot_v_d;
   logic [31:0] slot_inst_q, slot_inst_d;
   logic [31:0] slot_pc_q, slot_pc_d;
   logic        skid_v_q, skid_v_d;
   logic [31:0] skid_inst_q, skid_inst_d;
   logic [31:0] skid_pc_q, skid_pc_d;

   logic can_issue;
   logic rsp_in;
   logic handshake;

   // A new request is allowed in REQ, or in WAIT only alongside the returning response.
   assign can_issue = rst_ni && !stall_i && !redirect_valid_i && !skid_v_q;
   assign imem_req_valid_o = can_issue &&
                             ((state_q == ST_REQ) || ((state_q == ST_WAIT) && imem_rsp_valid_i));
   assign imem_addr_o = pc_q;
   assign handshake   = imem_req_valid_o && imem_req_ready_i;
   assign rsp_in      = (state_q == ST_WAIT) && imem_rsp_valid_i;

   assign instd_o = slot_inst_q;
   assign pcd_o   = slot_pc_q;
   assign flush_o = !slot_v_q || redirect_valid_i;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      req_pc_d    = req_pc_q;
      slot_v_d    = slot_v_q;
      slot_inst_d = slot_inst_q;
      slot_pc_d   = slot_pc_q;
      skid_v_d    = skid_v_q;
      skid_inst_d = skid_inst_q;
      skid_pc_d   = skid_pc_q;

      if (redirect_valid_i) begin
         pc_d     = redirect_pc_i;
         slot_v_d = 1'b0;
         skid_v_d = 1'b0;
         // A response still in flight must be swallowed before fetching the new target.
         if ((state_q == ST_WAIT || state_q == ST_DROP) && !imem_rsp_valid_i) begin
            state_d = ST_DROP;
         end else begin
            state_d = ST_REQ;
         end
      end else begin
         if (handshake) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + 32'd4;
         end

         if (!stall_i) begin
            if (skid_v_q) begin
               slot_v_d    = 1'b1;
               slot_inst_d = skid_inst_q;
               slot_pc_d   = skid_pc_q;
               skid_v_d    = 1'b0;
            end else if (rsp_in) begin
               slot_v_d    = 1'b1;
               slot_inst_d = imem_rsp_data_i;
               slot_pc_d   = req_pc_q;
            end else begin
               slot_v_d = 1'b0;
            end
         end else if (rsp_in) begin
            if (!slot_v_q) begin
               slot_v_d    = 1'b1;
               slot_inst_d = imem_rsp_data_i;
               slot_pc_d   = req_pc_q;
            end else begin
               skid_v_d    = 1'b1;
               skid_inst_d = imem_rsp_data_i;
               skid_pc_d   = req_pc_q;
            end
         end

         case (state_q)
            ST_REQ:  if (handshake) state_d = ST_WAIT;
            ST_WAIT: if (imem_rsp_valid_i) state_d = handshake ? ST_WAIT : ST_REQ;
            ST_DROP: if (imem_rsp_valid_i) state_d = ST_REQ;
            default: state_d = ST_REQ;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_REQ;
         pc_q        <= RESET_PC;
         req_pc_q    <= 32'd0;
         slot_v_q    <= 1'b0;
         slot_inst_q <= 32'd0;
         slot_pc_q   <= 32'd0;
         skid_v_q    <= 1'b0;
         skid_inst_q <= 32'd0;
         skid_pc_q   <= 32'd0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         req_pc_q    <= req_pc_d;
         slot_v_q    <= slot_v_d;
         slot_inst_q <= slot_inst_d;
         slot_pc_q   <= slot_pc_d;
         skid_v_q    <= skid_v_d;
         skid_inst_q <= skid_inst_d;
         skid_pc_q   <= skid_pc_d;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] bubble_cnt_q, bubble_cnt_d;

   // Saturates instead of wrapping so a long run never reads as few bubbles.
   always_comb begin
      bubble_cnt_d = bubble_cnt_q;
      if (flush_o && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
         bubble_cnt_d = bubble_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         bubble_cnt_q <= 32'd0;
      end else begin
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule
